// File: rtl/midi_note_receiver.sv
// MIDI serial front end: 8N1 receiver plus channel Note On/Off parser driving a
// monophonic last-note-priority gate.
module midi_note_receiver #(
  parameter int         CLK_HZ  = 100000000,
  parameter int         BAUD    = 31250,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [6:0] velocity,
  output logic       frame_error
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_done;

  logic          running, skip, two_byte, note_on, data_idx;
  logic [6:0]    note_buf;

  // Input synchronizer; rx_prev gives the falling-edge reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= midi_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit-centre sampling receiver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      rx_byte     <= '0;
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_done   <= 1'b0;
      frame_error <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            baud_cnt <= HALF_LOAD;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (baud_cnt == '0) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              baud_cnt <= FULL_LOAD;
              bit_idx  <= 3'd0;
              rx_state <= RX_DATA;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == '0) begin
            rx_byte  <= {rx_sync, rx_byte[7:1]};
            baud_cnt <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == '0) begin
            if (rx_sync) byte_done <= 1'b1;
            else         frame_error <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Message parser; skipped messages still consume their data bytes so
  // running status stays aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running    <= 1'b0;
      skip       <= 1'b0;
      two_byte   <= 1'b0;
      note_on    <= 1'b0;
      data_idx   <= 1'b0;
      note_buf   <= '0;
      midi_data  <= '0;
      midi_valid <= 1'b0;
      velocity   <= '0;
    end else if (byte_done) begin
      if (rx_byte[7]) begin
        if (rx_byte[7:4] == 4'hF) begin
          if (!rx_byte[3]) running <= 1'b0;
        end else begin
          running  <= 1'b1;
          data_idx <= 1'b0;
          note_on  <= (rx_byte[6:4] == 3'b001);
          skip     <= !((rx_byte[6:5] == 2'b00) && (rx_byte[3:0] == CHANNEL));
          two_byte <= !(rx_byte[6:5] == 2'b10);
        end
      end else if (running) begin
        if (!data_idx) begin
          note_buf <= rx_byte[6:0];
          data_idx <= two_byte;
        end else begin
          data_idx <= 1'b0;
          if (!skip) begin
            if (note_on && rx_byte[6:0] != 7'd0) begin
              midi_data  <= {1'b0, note_buf};
              velocity   <= rx_byte[6:0];
              midi_valid <= 1'b1;
            end else if (midi_valid && note_buf == midi_data[6:0]) begin
              midi_valid <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_note_receiver.sv
// Scoreboard bench for midi_note_receiver: a queue-based MIDI model predicts gate
// changes and frame errors; a monitor matches them against DUT output activity.
module tb_midi_note_receiver;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       midi_rx;
  logic [7:0] midi_data;
  logic       midi_valid;
  logic [6:0] velocity;
  logic       frame_error;

  midi_note_receiver #(.CLK_HZ(500000), .BAUD(31250), .CHANNEL(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .midi_rx(midi_rx), .midi_data(midi_data),
    .midi_valid(midi_valid), .velocity(velocity), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [6:0] vel;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   fe_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Reference model: status byte plus a queue of collected data bytes
  int         m_status = -1;
  int         m_data[$];
  logic [7:0] m_note = 8'd0;
  logic       m_valid = 1'b0;
  logic [6:0] m_vel = 7'd0;

  task automatic model_byte(input logic [7:0] b);
    int need, typ, note, vel;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_status = -1; m_data.delete(); return; end
    if (b >= 8'h80) begin m_status = int'(b); m_data.delete(); return; end
    if (m_status < 0) return;
    m_data.push_back(int'(b));
    typ  = m_status / 16;
    need = (typ == 12 || typ == 13) ? 1 : 2;
    if (m_data.size() == need) begin
      if ((typ == 8 || typ == 9) && (m_status % 16) == 0) begin
        note = m_data[0];
        vel  = m_data[1];
        if (typ == 9 && vel != 0) begin
          m_note = 8'(note); m_vel = 7'(vel); m_valid = 1'b1;
        end else if (m_valid && note == int'(m_note)) begin
          m_valid = 1'b0;
        end
      end
      m_data.delete();
    end
  endtask

  task automatic push_if_changed(input logic [15:0] old, input int at);
    exp_t e;
    if ({m_note, m_valid, m_vel} != old) begin
      e.d = m_note; e.v = m_valid; e.vel = m_vel; e.at = at;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    logic [15:0] old;
    old = {m_note, m_valid, m_vel};
    m_status = -1; m_data.delete();
    m_note = 8'd0; m_valid = 1'b0; m_vel = 7'd0;
    push_if_changed(old, -1);
    rst_n   = 1'b0;
    midi_rx = 1'b1;
    #1;
    checks++;
    if (midi_data !== 8'd0 || midi_valid !== 1'b0 || velocity !== 7'd0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got data=%h valid=%b vel=%h fe=%b, expected all zero",
               midi_data, midi_valid, velocity, frame_error);
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // mode 0: normal byte, 1: stop bit held low, 2: reset during data bit 4
  task automatic send_byte(input logic [7:0] b, input int mode);
    int t0;
    logic [15:0] old;
    t0 = cyc;
    if (mode == 0) begin
      old = {m_note, m_valid, m_vel};
      model_byte(b);
      push_if_changed(old, t0 + 156);
    end else if (mode == 1) begin
      fe_q.push_back(t0 + 155);
    end
    midi_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      if (mode == 2 && i == 4) begin
        repeat (DIV / 2) @(negedge clk);
        do_reset();
        return;
      end
      repeat (DIV) @(negedge clk);
    end
    midi_rx = (mode != 1);
    repeat (DIV) @(negedge clk);
    if (mode == 1) begin
      midi_rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 0); send_byte(b, 0); send_byte(c, 0);
  endtask

  task automatic check_state(input string name);
    repeat (20) @(negedge clk);
    checks++;
    if (midi_data !== m_note || midi_valid !== m_valid || velocity !== m_vel) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b vel=%h, expected data=%h valid=%b vel=%h",
               name, midi_data, midi_valid, velocity, m_note, m_valid, m_vel);
    end
  endtask

  // Monitor: every output change and every frame_error cycle must be predicted
  logic [15:0] prev_out;
  always @(negedge clk) begin
    if (mon_en) begin
      if ({midi_data, midi_valid, velocity} != prev_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got data=%h valid=%b vel=%h at cycle %0d, expected no change",
                   midi_data, midi_valid, velocity, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (midi_data !== e.d || midi_valid !== e.v || velocity !== e.vel) begin
            errors++;
            $display("FAIL out_value: got data=%h valid=%b vel=%h, expected data=%h valid=%b vel=%h",
                     midi_data, midi_valid, velocity, e.d, e.v, e.vel);
          end
          if (e.at >= 0) begin
            checks++;
            if (cyc != e.at) begin
              errors++;
              $display("FAIL out_latency: got cycle %0d, expected cycle %0d", cyc, e.at);
            end
          end
        end
        prev_out = {midi_data, midi_valid, velocity};
      end
      if (frame_error) begin
        checks++;
        if (fe_q.size() == 0) begin
          errors++;
          $display("FAIL frame_error_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          int at;
          at = fe_q.pop_front();
          if (cyc != at) begin
            errors++;
            $display("FAIL frame_error_time: got cycle %0d, expected cycle %0d", cyc, at);
          end
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    midi_rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (midi_data !== 8'd0 || midi_valid !== 1'b0 || velocity !== 7'd0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h valid=%b vel=%h fe=%b, expected all zero",
               midi_data, midi_valid, velocity, frame_error);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    prev_out = {midi_data, midi_valid, velocity};
    mon_en   = 1'b1;

    send3(8'h90, 8'h3C, 8'h64);
    check_state("basic_note_on");

    send_byte(8'h40, 0); send_byte(8'h50, 0);
    check_state("running_status_on");
    send_byte(8'h3C, 0); send_byte(8'h00, 0);
    check_state("off_other_note");
    send_byte(8'h40, 0); send_byte(8'h00, 0);
    check_state("off_held_note");

    send_byte(8'h90, 0); send_byte(8'hF8, 0); send_byte(8'h3C, 0);
    send_byte(8'hFE, 0); send_byte(8'h64, 0);
    check_state("realtime_interleave");
    send3(8'h91, 8'h3C, 8'h64);
    send_byte(8'h45, 0); send_byte(8'h7F, 0);
    check_state("other_channel");

    send3(8'h90, 8'h3C, 8'h64);
    send3(8'hF0, 8'h7E, 8'hF7);
    send_byte(8'h3E, 0); send_byte(8'h20, 0);
    check_state("sysex_clears_running");

    send_byte(8'h90, 1);
    check_state("frame_error_no_change");
    midi_rx = 1'b0;
    repeat (4) @(negedge clk);
    midi_rx = 1'b1;
    repeat (40) @(negedge clk);
    check_state("glitch_ignored");

    send3(8'h90, 8'h3C, 8'h64);
    send_byte(8'h90, 2);
    check_state("after_reset");
    send3(8'h90, 8'h30, 8'h10);
    check_state("note_after_reset");

    for (int m = 0; m < 16; m++) begin
      logic [7:0] n, v;
      n = 8'(8'h3C + $urandom_range(0, 3));
      v = 8'($urandom_range(1, 127));
      case ($urandom_range(0, 6))
        0: send3(8'h90, n, v);
        1: send3(8'h80, n, v);
        2: send3(8'h90, n, 8'h00);
        3: send3(8'(8'h90 + $urandom_range(1, 15)), n, v);
        4: begin send_byte(8'hC0, 0); send_byte(n, 0); end
        5: begin send_byte(n, 0); send_byte(v, 0); end
        default: send_byte(8'hF8, 0);
      endcase
    end
    check_state("random_end_state");

    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || fe_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outputs and %0d frame errors outstanding, expected 0 and 0",
               exp_q.size(), fe_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
